// File: rtl/lnk_pkg.sv
// rtl/lnk_pkg.sv - shared widths, null pointer and state encoding for the list-append walker
package lnk_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] NULL_PTR = '0;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CHECK,
    WR_VAL,
    WR_NXT,
    LINK,
    DONE
  } state_t;

endpackage

// File: rtl/lnk_append_if.sv
// rtl/lnk_append_if.sv - single-port synchronous memory bus between the walker and node storage
interface lnk_append_if #(
  parameter int ADDR_W = lnk_pkg::ADDR_W,
  parameter int DATA_W = lnk_pkg::DATA_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_wren,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_wren,
    output mem_rdata
  );

endinterface

// File: rtl/lnk_append.sv
// rtl/lnk_append.sv - walks a singly linked list to its tail and appends one node
module lnk_append #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MAX_HOPS = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] head_addr,
  input  logic [ADDR_W-1:0] new_addr,
  input  logic [DATA_W-1:0] new_value,
  lnk_append_if.master      mem,
  output logic              busy,
  output logic              done,
  output logic              new_head,
  output logic              err,
  output logic [ADDR_W-1:0] hop_count
);

  import lnk_pkg::*;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cur, cur_d;
  logic [ADDR_W-1:0] new_r, new_d;
  logic [DATA_W-1:0] val_r, val_d;
  logic [ADDR_W-1:0] hop_d;
  logic              new_head_r, new_head_d;
  logic              err_r, err_d;
  logic [ADDR_W-1:0] nxt;

  assign nxt = mem.mem_rdata[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur        <= '0;
      new_r      <= '0;
      val_r      <= '0;
      hop_count  <= '0;
      new_head_r <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state      <= state_d;
      cur        <= cur_d;
      new_r      <= new_d;
      val_r      <= val_d;
      hop_count  <= hop_d;
      new_head_r <= new_head_d;
      err_r      <= err_d;
    end
  end

  always_comb begin
    state_d       = state;
    cur_d         = cur;
    new_d         = new_r;
    val_d         = val_r;
    hop_d         = hop_count;
    new_head_d    = new_head_r;
    err_d         = err_r;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_wren  = 1'b0;
    busy          = (state != IDLE);
    done          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          new_d      = new_addr;
          val_d      = new_value;
          cur_d      = head_addr;
          hop_d      = '0;
          new_head_d = 1'b0;
          err_d      = 1'b0;
          if (new_addr == NULL_PTR || head_addr == new_addr) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (head_addr == NULL_PTR) begin
            new_head_d = 1'b1;
            state_d    = WR_VAL;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        mem.mem_addr = cur + ADDR_W'(1);
        state_d      = CHECK;
      end
      CHECK: begin
        // cur is left untouched on the tail exit so LINK can address tail+1
        hop_d = hop_count + ADDR_W'(1);
        if (nxt == NULL_PTR) begin
          state_d = WR_VAL;
        end else if (nxt == new_r || hop_d == ADDR_W'(MAX_HOPS)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cur_d   = nxt;
          state_d = RD;
        end
      end
      WR_VAL: begin
        mem.mem_addr  = new_r;
        mem.mem_wdata = val_r;
        mem.mem_wren  = 1'b1;
        state_d       = WR_NXT;
      end
      WR_NXT: begin
        mem.mem_addr  = new_r + ADDR_W'(1);
        mem.mem_wren  = 1'b1;
        state_d       = new_head_r ? DONE : LINK;
      end
      LINK: begin
        // Last write of the append: an earlier abort leaves only an unlinked node
        mem.mem_addr  = cur + ADDR_W'(1);
        mem.mem_wdata = DATA_W'(new_r);
        mem.mem_wren  = 1'b1;
        state_d       = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign new_head = done & new_head_r;
  assign err      = done & err_r;

endmodule
